compute_batch: RTL and testbench
================================

COMPUTE_BATCH -- requirements
Module: compute_batch

Interface
REQ-001 Parameter ENV_NUM, default 40: number of environment instances processed per step.
REQ-002 Parameter PE_NUM, default 20: number of physical step-compute lanes; ENV_NUM SHALL be an integer multiple of PE_NUM.
REQ-003 Parameters STA_WL 128, ACT_WL 1, OBS_WL 128, RWD_WL 1: per-environment state, action, observation and reward widths.
REQ-004 Derived NB = ENV_NUM/PE_NUM (batch count); batch index width SHALL be max(1, clog2(NB)).
REQ-005 i_clk  in  1  single clock; all logic rising-edge.
REQ-006 i_rstn  in  1  synchronous, active-low reset.
REQ-007 i_start  in  1  step request; accepted only when o_busy=0 and o_valid=0.
REQ-008 i_sta  in  ENV_NUM*STA_WL  current states, env e at [e*STA_WL +: STA_WL].
REQ-009 i_act  in  ENV_NUM*ACT_WL  actions, same packing.
REQ-010 i_init_sta  in  STA_WL  reset state (used only with the REQ-033 feature).
REQ-011 i_ready  in  1  consumer accepts results.
REQ-012 o_pe_ena  out  PE_NUM  per-lane start pulse to the lane array.
REQ-013 o_pe_sta / o_pe_act  out  PE_NUM*STA_WL / PE_NUM*ACT_WL  current-batch operands.
REQ-014 i_pe_sta / i_pe_obs / i_pe_rwd / i_pe_done / i_pe_valid  in  PE_NUM*{STA_WL,OBS_WL,RWD_WL,1,1}  lane results.
REQ-015 o_sta / o_obs / o_rwd / o_done  out  ENV_NUM*{STA_WL,OBS_WL,RWD_WL,1}  registered results for all environments.
REQ-016 o_valid  out  1  results complete; o_busy  out  1  step in progress; o_batch  out  batch-index width  current batch.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, DONE; reset state IDLE.
REQ-018 IDLE & i_start: latch i_sta/i_act into operand registers, batch:=0, go ISSUE next cycle; i_start otherwise ignored.
REQ-019 ISSUE: o_pe_ena all-ones for exactly one cycle, clear per-lane sticky flags, go WAIT.
REQ-020 o_pe_sta/o_pe_act SHALL present the slice of batch o_batch (envs o_batch*PE_NUM .. +PE_NUM-1) and stay stable through ISSUE and WAIT.
REQ-021 WAIT: for each lane k with i_pe_valid[k]=1 and flag[k]=0, capture lane k results into env o_batch*PE_NUM+k and set flag[k]; later valids on a flagged lane ignored.
REQ-022 Lanes complete independently and in any order; i_pe_valid during ISSUE is ignored.
REQ-023 When all flags are set (counting same-cycle captures): if o_batch=NB-1 go DONE, else o_batch+1 and go ISSUE next cycle.
REQ-024 DONE: o_valid=1 held until i_ready=1; on o_valid & i_ready go IDLE, o_valid=0 next cycle.
REQ-025 o_busy=1 in ISSUE and WAIT, else 0.
REQ-026 o_sta/o_obs/o_rwd/o_done hold last captured values while IDLE/DONE; only meaningful while o_valid=1.
REQ-027 i_start asserted in ISSUE, WAIT or DONE SHALL have no effect and SHALL not be queued.
REQ-028 Minimum step latency, with 1-cycle lanes: 1 + NB*2 cycles from accepted i_start to o_valid.
REQ-029 NB=1: o_batch constant 0; flow ISSUE->WAIT->DONE.

Reset
REQ-030 i_rstn=0 at a clock edge: FSM IDLE, o_batch 0, flags 0, o_pe_ena 0, o_valid 0, o_busy 0, all result and operand registers 0.
REQ-031 Reset mid-step SHALL abort the step; lane results arriving after reset release are ignored until the next ISSUE.

Configuration
REQ-032 Macro COMPUTE_BATCH_AUTORST_EN controls auto-reset of terminated episodes.
REQ-033 Defined: on capture with i_pe_done[k]=1, the stored o_sta slice SHALL be i_init_sta, o_done bit still 1, o_obs/o_rwd as produced.
REQ-034 Undefined: o_sta slice SHALL be i_pe_sta[k] unconditionally; i_init_sta unused.

Verification
REQ-035 ENV_NUM=4, PE_NUM=2, 1-cycle lanes, lane sta=in+1: start with sta {3,2,1,0} -> o_valid at cycle 5, o_sta {4,3,2,1}, two o_pe_ena pulses.
REQ-036 Same config, lane 1 valid 3 cycles before lane 0 in batch 0 -> both captured once, batch 1 issued only after lane 0.
REQ-037 i_ready held 0 for 10 cycles in DONE, i_start pulsed -> o_valid held, no restart; i_ready=1 -> IDLE next cycle.
REQ-038 i_rstn=0 during WAIT of batch 1 -> next cycle o_busy=0, o_batch=0, o_valid=0; new start completes normally.
REQ-039 AUTORST_EN defined, env 2 done=1, i_init_sta=0xA5 -> o_sta env 2 = 0xA5, o_done[2]=1; undefined -> lane state.
REQ-040 Lane emits duplicate valid with different data -> first value retained.

Source files
------------

// File: rtl/compute_batch.sv
// compute_batch: runs one simulation step for ENV_NUM environments by time-
// multiplexing them over PE_NUM step-compute lanes, one batch at a time.
// Optional feature macro: COMPUTE_BATCH_AUTORST_EN (when defined, environments
// that report done have their stored state replaced by i_init_sta).
module compute_batch #(
  parameter int ENV_NUM = 40,
  parameter int PE_NUM  = 20,
  parameter int STA_WL  = 128,
  parameter int ACT_WL  = 1,
  parameter int OBS_WL  = 128,
  parameter int RWD_WL  = 1,
  localparam int NB     = ENV_NUM / PE_NUM,
  localparam int BW     = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic                        i_start,
  input  logic [ENV_NUM*STA_WL-1:0]   i_sta,
  input  logic [ENV_NUM*ACT_WL-1:0]   i_act,
  input  logic [STA_WL-1:0]           i_init_sta,
  input  logic                        i_ready,
  output logic [PE_NUM-1:0]           o_pe_ena,
  output logic [PE_NUM*STA_WL-1:0]    o_pe_sta,
  output logic [PE_NUM*ACT_WL-1:0]    o_pe_act,
  input  logic [PE_NUM*STA_WL-1:0]    i_pe_sta,
  input  logic [PE_NUM*OBS_WL-1:0]    i_pe_obs,
  input  logic [PE_NUM*RWD_WL-1:0]    i_pe_rwd,
  input  logic [PE_NUM-1:0]           i_pe_done,
  input  logic [PE_NUM-1:0]           i_pe_valid,
  output logic [ENV_NUM*STA_WL-1:0]   o_sta,
  output logic [ENV_NUM*OBS_WL-1:0]   o_obs,
  output logic [ENV_NUM*RWD_WL-1:0]   o_rwd,
  output logic [ENV_NUM-1:0]          o_done,
  output logic                        o_valid,
  output logic                        o_busy,
  output logic [BW-1:0]               o_batch
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [BW-1:0] LAST_BATCH = BW'(NB - 1);

  state_t                      state_q, state_d;
  logic [BW-1:0]               batch_q, batch_d;
  logic [PE_NUM-1:0]           flag_q;
  logic [PE_NUM-1:0]           capture;
  logic [ENV_NUM*STA_WL-1:0]   opSta_q;
  logic [ENV_NUM*ACT_WL-1:0]   opAct_q;
  logic [ENV_NUM*STA_WL-1:0]   sta_q;
  logic [ENV_NUM*OBS_WL-1:0]   obs_q;
  logic [ENV_NUM*RWD_WL-1:0]   rwd_q;
  logic [ENV_NUM-1:0]          done_q;

`ifndef COMPUTE_BATCH_AUTORST_EN
  logic unusedInitSta;
  assign unusedInitSta = ^i_init_sta;
`endif

  // Next-state logic: batch sequencing and per-lane capture enables
  always_comb begin
    state_d = state_q;
    batch_d = batch_q;
    capture = '0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = ISSUE;
          batch_d = '0;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        capture = i_pe_valid & ~flag_q;
        if (&(flag_q | i_pe_valid)) begin
          if (batch_q == LAST_BATCH) begin
            state_d = DONE;
          end else begin
            batch_d = batch_q + 1'b1;
            state_d = ISSUE;
          end
        end
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and batch-index registers
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      batch_q <= '0;
    end else begin
      state_q <= state_d;
      batch_q <= batch_d;
    end
  end

  // Sticky per-lane completion flags, cleared at each batch issue
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      flag_q <= '0;
    end else if (state_q == ISSUE) begin
      flag_q <= '0;
    end else begin
      flag_q <= flag_q | capture;
    end
  end

  // Operand snapshot taken when a step is accepted
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      opSta_q <= '0;
      opAct_q <= '0;
    end else if (state_q == IDLE && i_start) begin
      opSta_q <= i_sta;
      opAct_q <= i_act;
    end
  end

  // Result capture: lane k of the current batch writes environment batch*PE_NUM+k
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      sta_q  <= '0;
      obs_q  <= '0;
      rwd_q  <= '0;
      done_q <= '0;
    end else begin
      for (int k = 0; k < PE_NUM; k++) begin
        if (capture[k]) begin
`ifdef COMPUTE_BATCH_AUTORST_EN
          sta_q[(int'(batch_q)*PE_NUM + k)*STA_WL +: STA_WL] <=
            i_pe_done[k] ? i_init_sta : i_pe_sta[k*STA_WL +: STA_WL];
`else
          sta_q[(int'(batch_q)*PE_NUM + k)*STA_WL +: STA_WL] <= i_pe_sta[k*STA_WL +: STA_WL];
`endif
          obs_q[(int'(batch_q)*PE_NUM + k)*OBS_WL +: OBS_WL] <= i_pe_obs[k*OBS_WL +: OBS_WL];
          rwd_q[(int'(batch_q)*PE_NUM + k)*RWD_WL +: RWD_WL] <= i_pe_rwd[k*RWD_WL +: RWD_WL];
          done_q[int'(batch_q)*PE_NUM + k]                   <= i_pe_done[k];
        end
      end
    end
  end

  assign o_pe_ena = {PE_NUM{state_q == ISSUE}};
  assign o_pe_sta = opSta_q[int'(batch_q)*PE_NUM*STA_WL +: PE_NUM*STA_WL];
  assign o_pe_act = opAct_q[int'(batch_q)*PE_NUM*ACT_WL +: PE_NUM*ACT_WL];
  assign o_sta    = sta_q;
  assign o_obs    = obs_q;
  assign o_rwd    = rwd_q;
  assign o_done   = done_q;
  assign o_valid  = (state_q == DONE);
  assign o_busy   = (state_q == ISSUE) || (state_q == WAIT);
  assign o_batch  = batch_q;

endmodule

// File: tb/tb_compute_batch.sv
// Self-checking bench for compute_batch with 4 environments over 2 lanes.
// A behavioural lane model answers each issue after a programmable delay;
// expected results come from an environment-level reference model.
module tb_compute_batch;

  localparam int ENV = 4;
  localparam int PE  = 2;
  localparam int NBT = ENV / PE;
`ifdef COMPUTE_BATCH_AUTORST_EN
  localparam bit AUTORST = 1'b1;
`else
  localparam bit AUTORST = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic [ENV*8-1:0] sta = '0;
  logic [ENV-1:0]   act = '0;
  logic [7:0]       initSta = '0;
  logic             ready = 1'b0;
  logic [PE-1:0]    peEna;
  logic [PE*8-1:0]  peStaOut;
  logic [PE-1:0]    peActOut;
  logic [PE*8-1:0]  peSta = '0;
  logic [PE*8-1:0]  peObs = '0;
  logic [PE-1:0]    peRwd = '0;
  logic [PE-1:0]    peDone = '0;
  logic [PE-1:0]    peValid = '0;
  logic [ENV*8-1:0] oSta;
  logic [ENV*8-1:0] oObs;
  logic [ENV-1:0]   oRwd;
  logic [ENV-1:0]   oDone;
  logic             oValid;
  logic             oBusy;
  logic             oBatch;

  int checks = 0;
  int errors = 0;

  int  laneDelay [PE] = '{1, 1};
  int  laneCnt   [PE] = '{0, 0};
  bit  dupArm    [PE] = '{0, 0};
  bit  dupMode = 1'b0;
  logic [7:0] laneOpSta [PE] = '{8'h00, 8'h00};
  logic       laneOpAct [PE] = '{1'b0, 1'b0};

  int stepLatency;
  int stepEna;
  bit stepTimeout;

  logic [ENV*8-1:0] expSta, expObs;
  logic [ENV-1:0]   expRwd, expDone;

  compute_batch #(
    .ENV_NUM(ENV), .PE_NUM(PE), .STA_WL(8), .ACT_WL(1), .OBS_WL(8), .RWD_WL(1)
  ) dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_sta(sta), .i_act(act),
    .i_init_sta(initSta), .i_ready(ready),
    .o_pe_ena(peEna), .o_pe_sta(peStaOut), .o_pe_act(peActOut),
    .i_pe_sta(peSta), .i_pe_obs(peObs), .i_pe_rwd(peRwd), .i_pe_done(peDone),
    .i_pe_valid(peValid),
    .o_sta(oSta), .o_obs(oObs), .o_rwd(oRwd), .o_done(oDone),
    .o_valid(oValid), .o_busy(oBusy), .o_batch(oBatch)
  );

  always #5 clk = ~clk;

  // Environment step rules shared by the lane model and the reference model
  function automatic logic [7:0] envSta(input logic [7:0] s);
    return s + 8'd1;
  endfunction
  function automatic logic [7:0] envObs(input logic [7:0] s, input logic a);
    return s ^ 8'h5A ^ {7'b0, a};
  endfunction
  function automatic logic envRwd(input logic [7:0] s, input logic a);
    return a ^ s[0];
  endfunction
  function automatic logic envDone(input logic [7:0] s);
    return s[7];
  endfunction

  // Reference: what every environment should hold after one full step
  function automatic void refStep(input logic [ENV*8-1:0] s, input logic [ENV-1:0] a,
                                  input logic [7:0] init);
    for (int e = 0; e < ENV; e++) begin
      logic [7:0] se;
      se = s[e*8 +: 8];
      expSta[e*8 +: 8] = (AUTORST && envDone(se)) ? init : envSta(se);
      expObs[e*8 +: 8] = envObs(se, a[e]);
      expRwd[e]        = envRwd(se, a[e]);
      expDone[e]       = envDone(se);
    end
  endfunction

  // Lane model: latches operands on its enable, answers after laneDelay cycles,
  // optionally repeats the valid once with corrupted data
  always @(posedge clk) begin
    for (int k = 0; k < PE; k++) begin
      peValid[k] <= 1'b0;
      if (peEna[k]) begin
        laneOpSta[k] <= peStaOut[k*8 +: 8];
        laneOpAct[k] <= peActOut[k];
        dupArm[k]    <= 1'b0;
        if (laneDelay[k] <= 1) begin
          peValid[k]       <= 1'b1;
          peSta[k*8 +: 8]  <= envSta(peStaOut[k*8 +: 8]);
          peObs[k*8 +: 8]  <= envObs(peStaOut[k*8 +: 8], peActOut[k]);
          peRwd[k]         <= envRwd(peStaOut[k*8 +: 8], peActOut[k]);
          peDone[k]        <= envDone(peStaOut[k*8 +: 8]);
          laneCnt[k]       <= 0;
          dupArm[k]        <= dupMode;
        end else begin
          laneCnt[k] <= laneDelay[k] - 1;
        end
      end else if (laneCnt[k] > 0) begin
        laneCnt[k] <= laneCnt[k] - 1;
        if (laneCnt[k] == 1) begin
          peValid[k]      <= 1'b1;
          peSta[k*8 +: 8] <= envSta(laneOpSta[k]);
          peObs[k*8 +: 8] <= envObs(laneOpSta[k], laneOpAct[k]);
          peRwd[k]        <= envRwd(laneOpSta[k], laneOpAct[k]);
          peDone[k]       <= envDone(laneOpSta[k]);
          dupArm[k]       <= dupMode;
        end
      end else if (dupArm[k]) begin
        peValid[k]      <= 1'b1;
        peSta[k*8 +: 8] <= ~envSta(laneOpSta[k]);
        peObs[k*8 +: 8] <= ~envObs(laneOpSta[k], laneOpAct[k]);
        peRwd[k]        <= ~envRwd(laneOpSta[k], laneOpAct[k]);
        peDone[k]       <= ~envDone(laneOpSta[k]);
        dupArm[k]       <= 1'b0;
      end
    end
  end

  // Drives one step from IDLE and waits for o_valid; leaves the bench at a negedge
  task automatic runStep(input logic [ENV*8-1:0] s, input logic [ENV-1:0] a,
                         input logic [7:0] init, input int d0, input int d1, input bit dup);
    @(negedge clk);
    laneDelay[0] = d0;
    laneDelay[1] = d1;
    dupMode = dup;
    sta = s;
    act = a;
    initSta = init;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    stepLatency = 1;
    stepEna = (peEna == 2'b11) ? 1 : 0;
    while (!oValid && stepLatency < 200) begin
      @(posedge clk);
      @(negedge clk);
      stepLatency++;
      if (peEna == 2'b11) stepEna++;
    end
    stepTimeout = !oValid;
    refStep(s, a, init);
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (oValid !== 1'b0 || oBusy !== 1'b0 || oBatch !== 1'b0 || peEna !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_ctrl valid=%b busy=%b batch=%b ena=%b required 0 0 0 00",
               oValid, oBusy, oBatch, peEna);
    end
    checks++;
    if (oSta !== '0 || oObs !== '0 || oRwd !== '0 || oDone !== '0 || peStaOut !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data sta=%h obs=%h rwd=%b done=%b pesta=%h required all zero",
               oSta, oObs, oRwd, oDone, peStaOut);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    runStep(32'h03020100, 4'b0000, 8'h00, 1, 1, 1'b0);
    checks++;
    if (stepTimeout || stepLatency != 5) begin
      errors++;
      $display("[TB] FAIL basic_latency got %0d required 5", stepLatency);
    end
    checks++;
    if (stepEna != 2) begin
      errors++;
      $display("[TB] FAIL basic_ena_pulses got %0d required 2", stepEna);
    end
    checks++;
    if (oSta !== 32'h04030201) begin
      errors++;
      $display("[TB] FAIL basic_sta got %h required 04030201", oSta);
    end
    checks++;
    if (oObs !== expObs || oRwd !== expRwd || oDone !== expDone) begin
      errors++;
      $display("[TB] FAIL basic_obs obs=%h rwd=%b done=%b required %h %b %b",
               oObs, oRwd, oDone, expObs, expRwd, expDone);
    end
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready = 1'b0;
    checks++;
    if (oValid !== 1'b0 || oBusy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_release valid=%b busy=%b required 0 0", oValid, oBusy);
    end
  endtask

  task automatic test_out_of_order;
    logic [ENV*8-1:0] s;
    int sawBatch1Early;
    s = {$urandom, $urandom} ;
    sawBatch1Early = 0;
    @(negedge clk);
    laneDelay[0] = 4;
    laneDelay[1] = 1;
    dupMode = 1'b0;
    sta = s;
    act = 4'($urandom);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    // Lane 1 answers in cycle 2, lane 0 in cycle 5; batch 1 must not appear before cycle 6
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (oBatch !== 1'b0) sawBatch1Early++;
    end
    checks++;
    if (sawBatch1Early != 0) begin
      errors++;
      $display("[TB] FAIL ooo_early_batch cycles_in_batch1=%0d required 0", sawBatch1Early);
    end
    stepLatency = 5;
    while (!oValid && stepLatency < 200) begin
      @(posedge clk);
      @(negedge clk);
      stepLatency++;
    end
    refStep(s, act, initSta);
    checks++;
    if (!oValid || stepLatency != 1 + NBT * 5) begin
      errors++;
      $display("[TB] FAIL ooo_latency got %0d required %0d", stepLatency, 1 + NBT * 5);
    end
    checks++;
    if (oSta !== expSta || oObs !== expObs || oRwd !== expRwd || oDone !== expDone) begin
      errors++;
      $display("[TB] FAIL ooo_results sta=%h obs=%h required %h %h", oSta, oObs, expSta, expObs);
    end
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic test_random;
    for (int it = 0; it < 6; it++) begin
      int d0, d1, mx;
      d0 = $urandom_range(1, 5);
      d1 = $urandom_range(1, 5);
      mx = (d0 > d1) ? d0 : d1;
      runStep({$urandom, $urandom}, 4'($urandom), 8'($urandom), d0, d1, 1'b0);
      checks++;
      if (stepTimeout || stepLatency != 1 + NBT * (1 + mx)) begin
        errors++;
        $display("[TB] FAIL rand_latency it=%0d got %0d required %0d", it, stepLatency,
                 1 + NBT * (1 + mx));
      end
      checks++;
      if (oSta !== expSta || oObs !== expObs || oRwd !== expRwd || oDone !== expDone) begin
        errors++;
        $display("[TB] FAIL rand_results it=%0d sta=%h obs=%h rwd=%b done=%b required %h %h %b %b",
                 it, oSta, oObs, oRwd, oDone, expSta, expObs, expRwd, expDone);
      end
      ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ready = 1'b0;
    end
  endtask

  task automatic test_ready_hold;
    int bad;
    bad = 0;
    runStep({$urandom, $urandom}, 4'($urandom), 8'h00, 2, 1, 1'b0);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        sta = {$urandom, $urandom};
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      if (oValid !== 1'b1 || oBusy !== 1'b0 || oSta !== expSta) bad++;
    end
    start = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL hold_valid bad_cycles=%0d required 0", bad);
    end
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready = 1'b0;
    checks++;
    if (oValid !== 1'b0 || oBusy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_release valid=%b busy=%b required 0 0", oValid, oBusy);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (oBusy !== 1'b0 || peEna !== 2'b00) begin
      errors++;
      $display("[TB] FAIL hold_no_queue busy=%b ena=%b required 0 00", oBusy, peEna);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    @(negedge clk);
    laneDelay[0] = 1;
    laneDelay[1] = 6;
    dupMode = 1'b0;
    sta = {$urandom, $urandom};
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(oBatch === 1'b1 && oBusy === 1'b1 && peEna === 2'b00) && n < 100) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("[TB] FAIL midrst_reach_wait1 waited=%0d required <100", n);
    end
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    checks++;
    if (oBusy !== 1'b0 || oBatch !== 1'b0 || oValid !== 1'b0 || oSta !== '0) begin
      errors++;
      $display("[TB] FAIL midrst_state busy=%b batch=%b valid=%b sta=%h required 0 0 0 0",
               oBusy, oBatch, oValid, oSta);
    end
    // The slow lane still answers after release; it must not land anywhere
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++;
    if (oSta !== '0 || oDone !== '0 || oBusy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_stale sta=%h done=%b busy=%b required 0 0 0", oSta, oDone, oBusy);
    end
    runStep({$urandom, $urandom}, 4'($urandom), 8'h00, 1, 1, 1'b0);
    checks++;
    if (stepTimeout || stepLatency != 5 || oSta !== expSta || oObs !== expObs) begin
      errors++;
      $display("[TB] FAIL midrst_restart lat=%0d sta=%h required 5 %h", stepLatency, oSta, expSta);
    end
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic test_duplicate;
    runStep({$urandom, $urandom}, 4'($urandom), 8'h00, 1, 4, 1'b1);
    checks++;
    if (stepTimeout || oSta !== expSta || oObs !== expObs || oRwd !== expRwd || oDone !== expDone) begin
      errors++;
      $display("[TB] FAIL dup_first_kept sta=%h obs=%h required %h %h", oSta, oObs, expSta, expObs);
    end
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready = 1'b0;
    dupMode = 1'b0;
  endtask

  task automatic test_autorst;
    logic [7:0] reqSta;
    runStep(32'h11851403, 4'b0101, 8'hA5, 1, 2, 1'b0);
    reqSta = AUTORST ? 8'hA5 : 8'h86;
    checks++;
    if (oSta[23:16] !== reqSta || oDone[2] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL autorst_env2 sta=%h done=%b required %h 1", oSta[23:16], oDone[2], reqSta);
    end
    checks++;
    if (oSta !== expSta || oObs !== expObs || oDone !== expDone) begin
      errors++;
      $display("[TB] FAIL autorst_all sta=%h done=%b required %h %b", oSta, oDone, expSta, expDone);
    end
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_out_of_order;
    test_random;
    test_ready_hold;
    test_reset_mid;
    test_duplicate;
    test_autorst;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
